build_packet: RTL

- Transmit-side header builder, downstream of the packet parser / forwarding logic.
- Accepts one set of Ethernet/IPv4/UDP header fields plus a payload length on a header handshake, then accepts the payload stream on `s_axis`.
- Emits a complete frame on `m_axis`: a 42-byte header followed by the payload, realigned across the 2-byte header remainder.
- Computes the IPv4 header checksum; the UDP checksum is sent as 0x0000.

---
 rtl/pkt_pkg.sv | 24 ++
 rtl/ipv4_csum.sv | 38 +++
 rtl/build_packet.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pkt_pkg.sv
// Shared types and constants for the transmit-side Ethernet/IPv4/UDP header builder.
package pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CSUM,
    HDR,
    BODY,
    TAIL,
    LAST
  } state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam int          HDR_BYTES      = 42;
  localparam logic [15:0] IP_HDR_LEN     = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN    = 16'd8;

  // Network order puts the MSB first, but byte 0 sits on the low lane.
  function automatic logic [15:0] swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

endpackage

// File: rtl/ipv4_csum.sv
// Combinational IPv4 header checksum over the ten header halfwords (checksum field as zero).
module ipv4_csum
  import pkt_pkg::*;
(
  input  logic [15:0] total_len,
  input  logic [7:0]  ttl,
  input  logic [31:0] ip_src,
  input  logic [31:0] ip_dst,
  output logic [15:0] csum
);

  logic [15:0] hw [10];
  logic [19:0] acc;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Ten 16-bit terms never exceed 20 bits; two end-around folds absorb every carry.
  always_comb begin
    hw[0] = 16'h4500;
    hw[1] = total_len;
    hw[2] = 16'h0000;
    hw[3] = 16'h4000;
    hw[4] = {ttl, IP_PROTO_UDP};
    hw[5] = 16'h0000;
    hw[6] = ip_src[31:16];
    hw[7] = ip_src[15:0];
    hw[8] = ip_dst[31:16];
    hw[9] = ip_dst[15:0];
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      acc = acc + {4'h0, hw[i]};
    end
    fold1 = {1'b0, acc[15:0]} + {13'h0, acc[19:16]};
    fold2 = fold1[15:0] + {15'h0, fold1[16]};
    csum  = ~fold2;
  end

endmodule

// File: rtl/build_packet.sv
// Transmit header builder: emits a 42-byte Eth/IPv4/UDP header, then the payload
// shifted by the 2-byte header remainder, through a single m_axis output register.
module build_packet
  import pkt_pkg::*;
#(
  parameter int IP_TTL = 64
) (
  input  logic        axis_clk,
  input  logic        axis_resetn,
  input  logic [47:0] dest_addr,
  input  logic [47:0] src_addr,
  input  logic [31:0] ip_src_addr,
  input  logic [31:0] ip_dest_addr,
  input  logic [15:0] udp_src_port,
  input  logic [15:0] udp_dest_port,
  input  logic [15:0] payload_len,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready
);

  localparam logic [7:0] TTL_BYTE = 8'(IP_TTL);

  state_t      state;
  logic [47:0] dest_q;
  logic [47:0] src_q;
  logic [31:0] ip_src_q;
  logic [31:0] ip_dst_q;
  logic [15:0] udp_src_q;
  logic [15:0] udp_dst_q;
  logic [15:0] len_q;
  logic [15:0] csum_q;
  logic [15:0] carry;
  logic [3:0]  word_idx;
  logic [3:0]  tail_keep;

  logic                   out_en;
  logic [15:0]            ip_total_len;
  logic [15:0]            udp_len;
  logic [15:0]            csum_next;
  logic [HDR_BYTES*8-1:0] hdr_flat;

  assign out_en        = !m_axis_tvalid || m_axis_tready;
  assign hdr_ready     = (state == IDLE);
  assign s_axis_tready = (state == BODY) && out_en;
  assign ip_total_len  = IP_HDR_LEN + UDP_HDR_LEN + len_q;
  assign udp_len       = UDP_HDR_LEN + len_q;

  ipv4_csum u_csum (
    .total_len (ip_total_len),
    .ttl       (TTL_BYTE),
    .ip_src    (ip_src_q),
    .ip_dst    (ip_dst_q),
    .csum      (csum_next)
  );

  // Whole header laid out with byte N at bits [8N+7:8N]; bytes 18-19 and 40-41 stay zero.
  always_comb begin
    hdr_flat = '0;
    for (int i = 0; i < 6; i++) begin
      hdr_flat[8*i +: 8]     = dest_q[47-8*i -: 8];
      hdr_flat[8*(6+i) +: 8] = src_q[47-8*i -: 8];
    end
    hdr_flat[96  +: 16] = swap16(ETHERTYPE_IPV4);
    hdr_flat[112 +: 16] = swap16(16'h4500);
    hdr_flat[128 +: 16] = swap16(ip_total_len);
    hdr_flat[160 +: 16] = swap16(16'h4000);
    hdr_flat[176 +: 16] = {IP_PROTO_UDP, TTL_BYTE};
    hdr_flat[192 +: 16] = swap16(csum_q);
    hdr_flat[208 +: 16] = swap16(ip_src_q[31:16]);
    hdr_flat[224 +: 16] = swap16(ip_src_q[15:0]);
    hdr_flat[240 +: 16] = swap16(ip_dst_q[31:16]);
    hdr_flat[256 +: 16] = swap16(ip_dst_q[15:0]);
    hdr_flat[272 +: 16] = swap16(udp_src_q);
    hdr_flat[288 +: 16] = swap16(udp_dst_q);
    hdr_flat[304 +: 16] = swap16(udp_len);
  end

  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state         <= IDLE;
      dest_q        <= '0;
      src_q         <= '0;
      ip_src_q      <= '0;
      ip_dst_q      <= '0;
      udp_src_q     <= '0;
      udp_dst_q     <= '0;
      len_q         <= '0;
      csum_q        <= '0;
      carry         <= '0;
      word_idx      <= '0;
      tail_keep     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      // A drained output slot empties unless the current state refills it below.
      if (out_en) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (hdr_valid) begin
            dest_q    <= dest_addr;
            src_q     <= src_addr;
            ip_src_q  <= ip_src_addr;
            ip_dst_q  <= ip_dest_addr;
            udp_src_q <= udp_src_port;
            udp_dst_q <= udp_dest_port;
            len_q     <= payload_len;
            state     <= CSUM;
          end
        end
        CSUM: begin
          csum_q   <= csum_next;
          word_idx <= '0;
          state    <= HDR;
        end
        HDR: begin
          if (out_en) begin
            m_axis_tdata  <= hdr_flat[{word_idx, 5'b0} +: 32];
            m_axis_tkeep  <= 4'hF;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
            if (word_idx == 4'd9) begin
              carry <= hdr_flat[320 +: 16];
              state <= (len_q == 16'd0) ? LAST : BODY;
            end else begin
              word_idx <= word_idx + 4'd1;
            end
          end
        end
        BODY: begin
          if (out_en && s_axis_tvalid) begin
            m_axis_tdata  <= {s_axis_tdata[15:0], carry};
            m_axis_tkeep  <= 4'hF;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
            carry         <= s_axis_tdata[31:16];
            // Two carried bytes decide whether the final input beat spills into a TAIL beat.
            if (s_axis_tlast) begin
              case (s_axis_tkeep)
                4'h1: begin
                  m_axis_tkeep <= 4'h7;
                  m_axis_tlast <= 1'b1;
                  state        <= IDLE;
                end
                4'h3: begin
                  m_axis_tlast <= 1'b1;
                  state        <= IDLE;
                end
                4'h7: begin
                  tail_keep <= 4'h1;
                  state     <= TAIL;
                end
                default: begin
                  tail_keep <= 4'h3;
                  state     <= TAIL;
                end
              endcase
            end
          end
        end
        TAIL: begin
          if (out_en) begin
            m_axis_tdata  <= {16'h0000, carry};
            m_axis_tkeep  <= tail_keep;
            m_axis_tlast  <= 1'b1;
            m_axis_tvalid <= 1'b1;
            state         <= IDLE;
          end
        end
        LAST: begin
          if (out_en) begin
            m_axis_tdata  <= {16'h0000, carry};
            m_axis_tkeep  <= 4'h3;
            m_axis_tlast  <= 1'b1;
            m_axis_tvalid <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
